// File: rtl/mux_out_fifo_if.sv
// Handshake and status bundle between the mux source, the output FIFO and its consumer.
interface mux_out_fifo_if #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 3
);
  logic                  push;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow;
  logic                  underflow;
  logic [ADDR_WIDTH:0]   count;

  // Driver side: issues push/pop and consumes data and status.
  modport master (
    output push, data_in, pop,
    input  data_out, valid_out, full, empty, almost_full, almost_empty,
           overflow, underflow, count
  );

  // FIFO side.
  modport slave (
    input  push, data_in, pop,
    output data_out, valid_out, full, empty, almost_full, almost_empty,
           overflow, underflow, count
  );
endinterface

// File: rtl/mux_out_fifo.sv
// Output buffer behind the 4:1 data mux: in-order storage, registered read
// port with one-cycle latency, occupancy flags and sticky over/underflow.
module mux_out_fifo #(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 2
) (
  input logic          clk,
  input logic          reset,
  mux_out_fifo_if.slave bus
);

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_CNT    = (ADDR_WIDTH+1)'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_out_q, valid_out_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic push_ok;
  logic pop_ok;

  // Accept decisions; a push into a full FIFO is allowed when a pop frees a slot
  // on the same edge. Pop only reads stored words, so no read-through.
  always_comb begin
    pop_ok  = bus.pop && (count_q != '0);
    push_ok = bus.push && ((count_q != DEPTH_CNT) || pop_ok);
  end

  // Next-state for pointers, occupancy, read register and sticky errors.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (pop_ok) begin
      data_out_d  = mem_q[rd_ptr_q];
      rd_ptr_d    = rd_ptr_q + 1'b1;
      valid_out_d = 1'b1;
    end
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (bus.push && !push_ok) begin
      overflow_d = 1'b1;
    end
    if (bus.pop && !pop_ok) begin
      underflow_d = 1'b1;
    end

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state register; reset takes effect immediately, independent of clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array; contents are left unreset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= bus.data_in;
    end
  end

  // Status flags decode the registered count directly.
  always_comb begin
    bus.data_out     = data_out_q;
    bus.valid_out    = valid_out_q;
    bus.count        = count_q;
    bus.full         = (count_q == DEPTH_CNT);
    bus.empty        = (count_q == '0);
    bus.almost_full  = (count_q >= AF_CNT);
    bus.almost_empty = (count_q <= AE_CNT);
    bus.overflow     = overflow_q;
    bus.underflow    = underflow_q;
  end

endmodule

// File: tb/tb_mux_out_fifo.sv
// Directed bench for mux_out_fifo: reset, fill/drain, overflow, underflow,
// pointer wrap with concurrent traffic, and asynchronous reset mid-stream.
module tb_mux_out_fifo;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  mux_out_fifo_if #(.DATA_WIDTH(12), .ADDR_WIDTH(3)) bus ();

  mux_out_fifo #(
    .DATA_WIDTH(12), .DEPTH(8), .ADDR_WIDTH(3), .AF_THRESH(6), .AE_THRESH(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus, then sample 1 time unit after the edge.
  task automatic step(input logic p, input logic [11:0] d, input logic r);
    bus.push    = p;
    bus.data_in = d;
    bus.pop     = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.push    = 1'b0;
    bus.data_in = '0;
    bus.pop     = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // Reset with push held high: nothing may be captured.
    reset       = 1'b1;
    bus.push    = 1'b1;
    bus.data_in = 12'hABC;
    bus.pop     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(bus.count), 0);
    check("rst_empty", 32'(bus.empty), 1);
    check("rst_aempty", 32'(bus.almost_empty), 1);
    check("rst_full", 32'(bus.full), 0);
    check("rst_afull", 32'(bus.almost_full), 0);
    check("rst_valid", 32'(bus.valid_out), 0);
    check("rst_dout", 32'(bus.data_out), 0);
    check("rst_ovf", 32'(bus.overflow), 0);
    check("rst_udf", 32'(bus.underflow), 0);
    reset = 1'b0;
    idle_inputs();
    step(1'b0, 12'h000, 1'b0);
    check("post_rst_count", 32'(bus.count), 0);

    // Fill 001..008.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 12'(i), 1'b0);
      check("fill_count", 32'(bus.count), 32'(i));
      check("fill_afull", 32'(bus.almost_full), (i >= 6) ? 1 : 0);
      check("fill_full", 32'(bus.full), (i == 8) ? 1 : 0);
      check("fill_empty", 32'(bus.empty), 0);
    end

    // Push into a full FIFO.
    step(1'b1, 12'hFFF, 1'b0);
    check("ovf_flag", 32'(bus.overflow), 1);
    check("ovf_count", 32'(bus.count), 8);
    check("ovf_valid", 32'(bus.valid_out), 0);

    // Drain: 001..008, never FFF.
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 12'h000, 1'b1);
      check("drain_valid", 32'(bus.valid_out), 1);
      check("drain_data", 32'(bus.data_out), 32'(i));
      check("drain_count", 32'(bus.count), 32'(8 - i));
      check("drain_aempty", 32'(bus.almost_empty), ((8 - i) <= 2) ? 1 : 0);
      check("drain_empty", 32'(bus.empty), (i == 8) ? 1 : 0);
      check("drain_ovf_sticky", 32'(bus.overflow), 1);
    end
    step(1'b0, 12'h000, 1'b0);
    check("idle_valid", 32'(bus.valid_out), 0);
    check("idle_dout_hold", 32'(bus.data_out), 12'h008);

    // Pop while empty.
    step(1'b0, 12'h000, 1'b1);
    check("udf_flag", 32'(bus.underflow), 1);
    check("udf_valid", 32'(bus.valid_out), 0);
    check("udf_dout_hold", 32'(bus.data_out), 12'h008);
    check("udf_count", 32'(bus.count), 0);

    // Push and pop together while empty: push wins, pop rejected.
    step(1'b1, 12'h123, 1'b1);
    check("pp_empty_count", 32'(bus.count), 1);
    check("pp_empty_valid", 32'(bus.valid_out), 0);
    check("pp_empty_udf", 32'(bus.underflow), 1);
    step(1'b0, 12'h000, 1'b1);
    check("pp_pop_data", 32'(bus.data_out), 12'h123);
    check("pp_pop_valid", 32'(bus.valid_out), 1);
    check("pp_pop_count", 32'(bus.count), 0);

    // Clear sticky flags before the wrap test.
    reset = 1'b1;
    step(1'b0, 12'h000, 1'b0);
    reset = 1'b0;
    check("clr_ovf", 32'(bus.overflow), 0);
    check("clr_udf", 32'(bus.underflow), 0);

    // Preload four words, then 20 cycles of concurrent push/pop.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 12'(12'h200 + i), 1'b0);
    end
    check("pre_count", 32'(bus.count), 4);
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 12'(12'h204 + k), 1'b1);
      check("wrap_data", 32'(bus.data_out), 32'(12'h200 + k));
      check("wrap_valid", 32'(bus.valid_out), 1);
      check("wrap_count", 32'(bus.count), 4);
      check("wrap_full", 32'(bus.full), 0);
      check("wrap_empty", 32'(bus.empty), 0);
    end
    check("wrap_ovf", 32'(bus.overflow), 0);
    check("wrap_udf", 32'(bus.underflow), 0);

    // Full with push and pop together: both accepted, no overflow.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 12'(12'h300 + i), 1'b0);
    end
    check("full2_count", 32'(bus.count), 8);
    step(1'b1, 12'h3AA, 1'b1);
    check("full_pp_count", 32'(bus.count), 8);
    check("full_pp_ovf", 32'(bus.overflow), 0);
    check("full_pp_data", 32'(bus.data_out), 12'h214);

    // Bring count to 5, then assert reset between clock edges.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 12'h000, 1'b1);
    end
    check("mid_count", 32'(bus.count), 5);
    idle_inputs();
    #3;
    reset = 1'b1;
    #1;
    check("async_count", 32'(bus.count), 0);
    check("async_empty", 32'(bus.empty), 1);
    check("async_valid", 32'(bus.valid_out), 0);
    check("async_dout", 32'(bus.data_out), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b1, 12'h055, 1'b0);
    check("after_rst_count", 32'(bus.count), 1);
    step(1'b0, 12'h000, 1'b1);
    check("after_rst_data", 32'(bus.data_out), 12'h055);
    check("after_rst_valid", 32'(bus.valid_out), 1);
    check("after_rst_empty", 32'(bus.empty), 1);

    idle_inputs();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
